// File: rtl/kernel_ctrl_pkg.sv
// Shared types and sizing for the kernel bank load/read sequencer.
// Imported by the coefficient-stream interface and the controller.
package kernel_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        READY,
        READ
    } kctrl_state_t;

    localparam int KCTRL_WIDTH    = 16;
    localparam int KCTRL_NUM_CH   = 16;
    localparam int KCTRL_NUM_COEF = 18;
    localparam int KCTRL_ADDR_W   = 5;

endpackage

// File: rtl/kernel_load_ctrl_if.sv
// Valid/ready coefficient stream from the loader/DMA into the controller.
// master = loader side, slave = controller side.
interface kernel_load_ctrl_if
    import kernel_ctrl_pkg::*;
#(
    parameter int WIDTH = KCTRL_WIDTH
);

    logic             coef_valid;
    logic             coef_ready;
    logic [WIDTH-1:0] coef_data;

    modport master (
        output coef_valid,
        output coef_data,
        input  coef_ready
    );

    modport slave (
        input  coef_valid,
        input  coef_data,
        output coef_ready
    );

endinterface

// File: rtl/kernel_load_ctrl.sv
// Load/read sequencer for the 16-unit kernel register bank.
// Channel-major load with registered writes; fixed-length read sweep.
module kernel_load_ctrl
    import kernel_ctrl_pkg::*;
#(
    parameter int WIDTH    = KCTRL_WIDTH,
    parameter int NUM_CH   = KCTRL_NUM_CH,
    parameter int NUM_COEF = KCTRL_NUM_COEF,
    parameter int ADDR_W   = KCTRL_ADDR_W
) (
    input  logic              clk,
    input  logic              arst_n_in,
    input  logic              load_start,
    input  logic              read_start,
    kernel_load_ctrl_if.slave coef_if,
    output logic [ADDR_W-1:0] kernel_write_addr,
    output logic [NUM_CH-1:0] kernel_we,
    output logic [WIDTH-1:0]  kernel_din,
    output logic [ADDR_W-1:0] kernel_read_addr,
    output logic              kernel_re,
    output logic              read_last,
    output logic              loaded,
    output logic              busy
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [CH_W-1:0]   CH_LAST   = CH_W'(NUM_CH - 1);
    localparam logic [ADDR_W-1:0] COEF_LAST = ADDR_W'(NUM_COEF - 1);

    kctrl_state_t      state_q;
    logic [CH_W-1:0]   ch_cnt_q;
    logic [ADDR_W-1:0] coef_cnt_q;
    logic [NUM_CH-1:0] we_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [WIDTH-1:0]  din_q;
    logic [ADDR_W-1:0] raddr_q;
    logic              re_q;
    logic              last_q;
    logic              loaded_q;

    logic              accept;
    logic [ADDR_W-1:0] raddr_d;

    assign coef_if.coef_ready = (state_q == LOAD);
    assign accept  = coef_if.coef_valid && coef_if.coef_ready;
    assign raddr_d = raddr_q + ADDR_W'(1);

    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            state_q    <= IDLE;
            ch_cnt_q   <= '0;
            coef_cnt_q <= '0;
            we_q       <= '0;
            waddr_q    <= '0;
            din_q      <= '0;
            raddr_q    <= '0;
            re_q       <= 1'b0;
            last_q     <= 1'b0;
            loaded_q   <= 1'b0;
        end else begin
            // Write and read strobes are single-cycle pulses.
            we_q   <= '0;
            re_q   <= 1'b0;
            last_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (load_start) begin
                        state_q    <= LOAD;
                        ch_cnt_q   <= '0;
                        coef_cnt_q <= '0;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        we_q    <= NUM_CH'(1) << ch_cnt_q;
                        waddr_q <= coef_cnt_q;
                        din_q   <= coef_if.coef_data;
                        if (coef_cnt_q == COEF_LAST) begin
                            coef_cnt_q <= '0;
                            if (ch_cnt_q == CH_LAST) begin
                                ch_cnt_q <= '0;
                                state_q  <= READY;
                                loaded_q <= 1'b1;
                            end else begin
                                ch_cnt_q <= ch_cnt_q + CH_W'(1);
                            end
                        end else begin
                            coef_cnt_q <= coef_cnt_q + ADDR_W'(1);
                        end
                    end
                end
                READY: begin
                    // Reload wins over a simultaneous read request.
                    if (load_start) begin
                        state_q    <= LOAD;
                        loaded_q   <= 1'b0;
                        ch_cnt_q   <= '0;
                        coef_cnt_q <= '0;
                    end else if (read_start) begin
                        state_q <= READ;
                        re_q    <= 1'b1;
                        raddr_q <= '0;
                        last_q  <= (NUM_COEF == 1);
                    end
                end
                READ: begin
                    if (raddr_q == COEF_LAST) begin
                        state_q <= READY;
                    end else begin
                        re_q    <= 1'b1;
                        raddr_q <= raddr_d;
                        last_q  <= (raddr_d == COEF_LAST);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign kernel_we         = we_q;
    assign kernel_write_addr = waddr_q;
    assign kernel_din        = din_q;
    assign kernel_read_addr  = raddr_q;
    assign kernel_re         = re_q;
    assign read_last         = last_q;
    assign loaded            = loaded_q;
    assign busy              = (state_q == LOAD) || (state_q == READ);

endmodule

// File: tb/tb_kernel_load_ctrl.sv
// Directed bench for kernel_load_ctrl: load, gaps, sweep, priority, reset.
// Inputs change on negedge; outputs are checked on negedge.
module tb_kernel_load_ctrl;

    localparam int W  = 16;
    localparam int NC = 16;
    localparam int NK = 18;
    localparam int AW = 5;
    localparam int TOTAL = NC * NK;

    logic          clk;
    logic          arst_n_in;
    logic          load_start;
    logic          read_start;
    logic [AW-1:0] kernel_write_addr;
    logic [NC-1:0] kernel_we;
    logic [W-1:0]  kernel_din;
    logic [AW-1:0] kernel_read_addr;
    logic          kernel_re;
    logic          read_last;
    logic          loaded;
    logic          busy;

    int errors = 0;
    int checks = 0;

    kernel_load_ctrl_if #(.WIDTH(W)) cif ();

    kernel_load_ctrl #(
        .WIDTH(W), .NUM_CH(NC), .NUM_COEF(NK), .ADDR_W(AW)
    ) dut (
        .clk              (clk),
        .arst_n_in        (arst_n_in),
        .load_start       (load_start),
        .read_start       (read_start),
        .coef_if          (cif),
        .kernel_write_addr(kernel_write_addr),
        .kernel_we        (kernel_we),
        .kernel_din       (kernel_din),
        .kernel_read_addr (kernel_read_addr),
        .kernel_re        (kernel_re),
        .read_last        (read_last),
        .loaded           (loaded),
        .busy             (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        logic [63:0] outs;
        arst_n_in = 1'b0;
        load_start = 1'b0;
        read_start = 1'b0;
        cif.coef_valid = 1'b0;
        cif.coef_data = '0;
        @(negedge clk);
        @(negedge clk);
        outs = 64'({kernel_we, kernel_write_addr, kernel_din, kernel_read_addr,
                    kernel_re, read_last, loaded, busy, cif.coef_ready});
        checks++;
        if (outs !== 64'h0) begin
            errors++;
            $display("FAIL reset_outs: got %h want 0", outs);
        end
        arst_n_in = 1'b1;
        @(negedge clk);
        outs = 64'({kernel_we, kernel_re, loaded, busy, cif.coef_ready});
        checks++;
        if (outs !== 64'h0) begin
            errors++;
            $display("FAIL post_reset_idle: got %h want 0", outs);
        end
    endtask

    // Full 288-beat load with data=k; optional random valid gaps.
    task automatic test_load(input bit gaps, input string tag);
        int k = 0;
        int nxt;
        int pulses = 0;
        int cyc = 0;
        logic [NC-1:0] one = 16'h1;
        logic [NC-1:0] exp_we;
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        checks++;
        if (busy !== 1'b1 || loaded !== 1'b0 || cif.coef_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_enter: busy=%b loaded=%b rdy=%b want 1 0 1",
                     tag, busy, loaded, cif.coef_ready);
        end
        while (k < TOTAL && cyc < 3000) begin
            if (!gaps || $urandom_range(0, 1) == 1) begin
                cif.coef_valid = 1'b1;
                cif.coef_data = W'(k);
                nxt = k;
                k++;
            end else begin
                cif.coef_valid = 1'b0;
                cif.coef_data = W'($urandom);
                nxt = -1;
            end
            @(negedge clk);
            cyc++;
            checks++;
            if (nxt >= 0) begin
                exp_we = one << (nxt / NK);
                if (kernel_we !== 16'h0) pulses++;
                if (kernel_we !== exp_we || kernel_write_addr !== AW'(nxt % NK) ||
                    kernel_din !== W'(nxt) || loaded !== (nxt == TOTAL - 1)) begin
                    errors++;
                    if (errors < 20)
                        $display("FAIL %s_beat%0d: we=%h a=%0d d=%0d ld=%b want %h %0d %0d %b",
                                 tag, nxt, kernel_we, kernel_write_addr, kernel_din,
                                 loaded, exp_we, nxt % NK, nxt, nxt == TOTAL - 1);
                end
            end else begin
                if (kernel_we !== 16'h0) pulses++;
                if (kernel_we !== 16'h0) begin
                    errors++;
                    if (errors < 20)
                        $display("FAIL %s_gap_write: we=%h want 0", tag, kernel_we);
                end
            end
        end
        cif.coef_valid = 1'b0;
        checks++;
        if (k != TOTAL || pulses != TOTAL) begin
            errors++;
            $display("FAIL %s_pulse_count: beats=%0d pulses=%0d want %0d",
                     tag, k, pulses, TOTAL);
        end
        @(negedge clk);
        checks++;
        if (kernel_we !== 16'h0 || loaded !== 1'b1 || busy !== 1'b0 ||
            cif.coef_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s_ready: we=%h loaded=%b busy=%b rdy=%b want 0 1 0 0",
                     tag, kernel_we, loaded, busy, cif.coef_ready);
        end
    endtask

    task automatic test_back_to_back();
        test_load(1'b0, "b2b");
    endtask

    task automatic test_gaps();
        test_load(1'b1, "gaps");
    endtask

    // Sweep; optionally pulse load_start while the address is 5.
    task automatic test_read_sweep(input bit poke, input string tag);
        read_start = 1'b1;
        for (int i = 0; i < NK; i++) begin
            @(negedge clk);
            read_start = 1'b0;
            load_start = poke && (i == 5);
            checks++;
            if (kernel_re !== 1'b1 || kernel_read_addr !== AW'(i) ||
                read_last !== (i == NK - 1) || busy !== 1'b1) begin
                errors++;
                $display("FAIL %s_addr%0d: re=%b a=%0d last=%b busy=%b want 1 %0d %b 1",
                         tag, i, kernel_re, kernel_read_addr, read_last, busy,
                         i, i == NK - 1);
            end
        end
        load_start = 1'b0;
        @(negedge clk);
        checks++;
        if (kernel_re !== 1'b0 || read_last !== 1'b0 || kernel_read_addr !== AW'(NK - 1) ||
            busy !== 1'b0 || loaded !== 1'b1) begin
            errors++;
            $display("FAIL %s_end: re=%b last=%b a=%0d busy=%b ld=%b want 0 0 17 0 1",
                     tag, kernel_re, read_last, kernel_read_addr, busy, loaded);
        end
    endtask

    task automatic test_idle_ignore();
        test_reset();
        read_start = 1'b1;
        cif.coef_valid = 1'b1;
        cif.coef_data = 16'h1234;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (cif.coef_ready !== 1'b0) begin
                errors++;
                $display("FAIL idle_ready%0d: got %b want 0", i, cif.coef_ready);
            end
            @(negedge clk);
            checks++;
            if (kernel_re !== 1'b0 || kernel_we !== 16'h0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL idle_ignore%0d: re=%b we=%h busy=%b want 0 0 0",
                         i, kernel_re, kernel_we, busy);
            end
        end
        read_start = 1'b0;
        cif.coef_valid = 1'b0;
        test_load(1'b0, "idle_load");
        load_start = 1'b1;
        read_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        read_start = 1'b0;
        checks++;
        if (busy !== 1'b1 || loaded !== 1'b0 || cif.coef_ready !== 1'b1 ||
            kernel_re !== 1'b0) begin
            errors++;
            $display("FAIL both_start: busy=%b ld=%b rdy=%b re=%b want 1 0 1 0",
                     busy, loaded, cif.coef_ready, kernel_re);
        end
    endtask

    task automatic test_reset_mid_load();
        logic [63:0] outs;
        test_reset();
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        for (int k = 0; k < 100; k++) begin
            cif.coef_valid = 1'b1;
            cif.coef_data = W'(k + 16'h100);
            @(negedge clk);
        end
        arst_n_in = 1'b0;
        #1;
        outs = 64'({kernel_we, kernel_write_addr, kernel_din, kernel_read_addr,
                    kernel_re, read_last, loaded, busy, cif.coef_ready});
        checks++;
        if (outs !== 64'h0) begin
            errors++;
            $display("FAIL mid_load_reset: got %h want 0", outs);
        end
        @(negedge clk);
        cif.coef_valid = 1'b0;
        arst_n_in = 1'b1;
        @(negedge clk);
        test_load(1'b0, "reload");
    endtask

    task automatic test_load_during_read();
        test_read_sweep(1'b1, "rd_poke");
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        checks++;
        if (busy !== 1'b1 || loaded !== 1'b0 || cif.coef_ready !== 1'b1) begin
            errors++;
            $display("FAIL load_after_sweep: busy=%b ld=%b rdy=%b want 1 0 1",
                     busy, loaded, cif.coef_ready);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_read_sweep(1'b0, "sweep");
        test_gaps();
        test_idle_ignore();
        test_reset_mid_load();
        test_load_during_read();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
